// File: rtl/mips_mem_port.sv
// mips_mem_port: memory-side handshake stage for the multicycle MIPS datapath.
// It turns a one-cycle controller request into a held mem_en/mem_ack transaction
// toward a variable-latency memory. When the transaction ends it returns a
// one-cycle resp_valid pulse, qualified by resp_err, so the controller can stall
// in place until the response arrives.
//
// Ports
//   clk, rst                     rising-edge clock, asynchronous active-low reset
//   req_valid/we/addr/wdata      controller request (sampled only while req_ready)
//   req_ready                    port idle (combinational, state == IDLE)
//   resp_valid, resp_err         completion pulse; err = misaligned or timeout
//   rdata                        last successfully read word
//   mem_en/we/addr/wdata         memory request, held stable until ack/timeout
//   mem_ack, mem_rdata           memory completion and read data
module mips_mem_port #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Next-state logic. resp_valid/resp_err are set on the edge that enters DONE,
  // so they are high exactly while the FSM sits in DONE.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_addr[1:0] != 2'b00) begin
            // Misaligned: fail without touching memory or the mem_* registers.
            state_d      = StDone;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d     = StReq;
            cnt_d       = '0;
            mem_en_d    = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = req_addr;
            mem_wdata_d = req_wdata;
          end
        end
      end
      StReq: begin
        // Ack takes priority over a coincident timeout.
        if (mem_ack) begin
          mem_en_d     = 1'b0;
          mem_we_d     = 1'b0;
          if (!mem_we_q) rdata_d = mem_rdata;
          state_d      = StDone;
          resp_valid_d = 1'b1;
        end else if (cnt_q == CntLast) begin
          mem_en_d     = 1'b0;
          mem_we_d     = 1'b0;
          state_d      = StDone;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: everything registered except req_ready.
  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = resp_valid_q;
    resp_err   = resp_err_q;
    rdata      = rdata_q;
    mem_en     = mem_en_q;
    mem_we     = mem_we_q;
    mem_addr   = mem_addr_q;
    mem_wdata  = mem_wdata_q;
  end

endmodule

// File: tb/tb_mips_mem_port.sv
// Self-checking bench for mips_mem_port: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_mips_mem_port;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready, resp_valid, resp_err;
  logic [DW-1:0] rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mips_mem_port #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_err  (resp_err),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] rd_model;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: a misaligned address fails at once; an ack in REQ
  // cycle j (0-based) completes after j+1 mem_en cycles; no ack fails after TO.
  function automatic void model(input logic [31:0] addr, input int ack_at, output int lat,
                                output logic err, output int en, output bit acked);
    acked = 1'b0;
    if (addr[1:0] != 2'b00) begin
      lat = 1; err = 1'b1; en = 0;
    end else if (ack_at >= 0 && ack_at < int'(TO)) begin
      lat = ack_at + 2; err = 1'b0; en = ack_at + 1; acked = 1'b1;
    end else begin
      lat = int'(TO) + 1; err = 1'b1; en = int'(TO);
    end
  endfunction

  // Drives one request, plays memory (ack in REQ cycle ack_at, -1 = never) and
  // records what the port did. Noise acks are driven whenever mem_en is low.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int ack_at, input logic [31:0] mrdata, input bit poke,
                         output int lat, output logic err, output int en_cyc,
                         output bit stable, output int nresp);
    lat = -1; err = 1'b0; en_cyc = 0; stable = 1'b1; nresp = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; mem_ack = 1'b0;
    step();
    if (poke) begin
      // Keep requesting something else while busy; it must be ignored.
      req_addr = $urandom & 32'hFFFF_FFFC; req_we = ~we; req_wdata = $urandom;
    end else begin
      req_valid = 1'b0;
    end
    for (int cyc = 1; cyc <= int'(TO) + 8; cyc++) begin
      if (resp_valid) begin
        nresp++;
        if (lat < 0) begin lat = cyc; err = resp_err; end
        req_valid = 1'b0;
      end
      if (mem_en) begin
        en_cyc++;
        if (mem_we !== we || mem_addr !== addr || mem_wdata !== wdata) stable = 1'b0;
      end
      if (mem_en && (en_cyc - 1) == ack_at) begin
        mem_ack = 1'b1; mem_rdata = mrdata;
      end else begin
        mem_ack = mem_en ? 1'b0 : 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      end
      if (lat > 0 && cyc >= lat + 2) break;
      step();
    end
    mem_ack = 1'b0; req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #3;
    n_cmp++; if ({mem_en, mem_we, resp_valid, resp_err} !== 4'b0000) begin n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000", {mem_en, mem_we, resp_valid, resp_err}); end
    n_cmp++; if ({mem_addr, mem_wdata, rdata} !== 96'h0) begin n_fail++;
      $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, rdata}); end
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_ready: got %b want 1", req_ready); end
    rd_model = '0;
    @(negedge clk); rst = 1'b1;
    step();
  endtask

  task automatic test_zero_wait_read();
    int lat, en, nr; logic err; bit st;
    run_txn(1'b0, 32'h0000_0010, $urandom, 0, 32'h2108_0004, 1'b0, lat, err, en, st, nr);
    rd_model = 32'h2108_0004;
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL zw_latency: got %0d want 2", lat); end
    n_cmp++; if (en !== 1) begin n_fail++; $display("FAIL zw_en_cycles: got %0d want 1", en); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL zw_err: got %b want 0", err); end
    n_cmp++; if (rdata !== rd_model) begin n_fail++;
      $display("FAIL zw_rdata: got %h want %h", rdata, rd_model); end
  endtask

  task automatic test_wait_write();
    int lat, en, nr; logic err; bit st;
    run_txn(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 2, $urandom, 1'b0, lat, err, en, st, nr);
    n_cmp++; if (en !== 3) begin n_fail++; $display("FAIL ww_en_cycles: got %0d want 3", en); end
    n_cmp++; if (st !== 1'b1) begin n_fail++; $display("FAIL ww_stable: got %b want 1", st); end
    n_cmp++; if (lat !== 4 || err !== 1'b0 || nr !== 1) begin n_fail++;
      $display("FAIL ww_resp: got lat=%0d err=%b n=%0d want lat=4 err=0 n=1", lat, err, nr); end
    n_cmp++; if (rdata !== rd_model) begin n_fail++;
      $display("FAIL ww_rdata_kept: got %h want %h", rdata, rd_model); end
  endtask

  task automatic test_timeout();
    int lat, en, nr; logic err; bit st;
    run_txn(1'b0, 32'h0000_0200, $urandom, -1, $urandom, 1'b0, lat, err, en, st, nr);
    n_cmp++; if (en !== 15) begin n_fail++; $display("FAIL to_en_cycles: got %0d want 15", en); end
    n_cmp++; if (lat !== 16 || err !== 1'b1) begin n_fail++;
      $display("FAIL to_resp: got lat=%0d err=%b want lat=16 err=1", lat, err); end
    n_cmp++; if (rdata !== rd_model) begin n_fail++;
      $display("FAIL to_rdata_kept: got %h want %h", rdata, rd_model); end
  endtask

  task automatic test_ack_last();
    int lat, en, nr; logic err; bit st; logic [31:0] d;
    d = $urandom;
    run_txn(1'b0, 32'h0000_0300, $urandom, 14, d, 1'b0, lat, err, en, st, nr);
    rd_model = d;
    n_cmp++; if (lat !== 16 || err !== 1'b0) begin n_fail++;
      $display("FAIL al_resp: got lat=%0d err=%b want lat=16 err=0", lat, err); end
    n_cmp++; if (rdata !== rd_model) begin n_fail++;
      $display("FAIL al_rdata: got %h want %h", rdata, rd_model); end
  endtask

  task automatic test_misaligned_busy();
    int lat, en, nr; logic err; bit st;
    run_txn(1'b0, 32'h0000_0006, $urandom, 0, $urandom, 1'b0, lat, err, en, st, nr);
    n_cmp++; if (en !== 0) begin n_fail++; $display("FAIL mis_en_cycles: got %0d want 0", en); end
    n_cmp++; if (lat !== 1 || err !== 1'b1 || nr !== 1) begin n_fail++;
      $display("FAIL mis_resp: got lat=%0d err=%b n=%0d want lat=1 err=1 n=1", lat, err, nr); end
    run_txn(1'b1, 32'h0000_0404, $urandom, 3, $urandom, 1'b1, lat, err, en, st, nr);
    n_cmp++; if (nr !== 1 || st !== 1'b1) begin n_fail++;
      $display("FAIL busy_ignored: got n=%0d stable=%b want n=1 stable=1", nr, st); end
    n_cmp++; if (lat !== 5 || err !== 1'b0) begin n_fail++;
      $display("FAIL busy_resp: got lat=%0d err=%b want lat=5 err=0", lat, err); end
  endtask

  task automatic test_reset_mid_req();
    int seen;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0040; req_wdata = '0; mem_ack = 1'b0;
    step();
    req_valid = 1'b0;
    step(); step();
    n_cmp++; if (mem_en !== 1'b1) begin n_fail++;
      $display("FAIL rst_pre_en: got %b want 1", mem_en); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (mem_en !== 1'b0 || resp_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_async: got en=%b rv=%b want 0 0", mem_en, resp_valid); end
    rd_model = '0;
    @(negedge clk); rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      mem_ack = 1'b1;
      if (resp_valid) seen++;
    end
    mem_ack = 1'b0;
    n_cmp++; if (seen !== 0 || req_ready !== 1'b1) begin n_fail++;
      $display("FAIL rst_after: got resp=%0d ready=%b want 0 1", seen, req_ready); end
    n_cmp++; if (rdata !== rd_model) begin n_fail++;
      $display("FAIL rst_rdata: got %h want %h", rdata, rd_model); end
  endtask

  task automatic test_random();
    int lat, en, nr, e_lat, e_en, ack_at; logic err, e_err; bit st, acked, we, poke;
    logic [31:0] addr, d;
    for (int t = 0; t < 40; t++) begin
      we     = 1'($urandom_range(0, 1));
      addr   = $urandom;
      if ($urandom_range(0, 4) != 0) addr[1:0] = 2'b00;
      ack_at = $urandom_range(0, int'(TO) + 2) - 1;
      poke   = 1'($urandom_range(0, 1));
      d      = $urandom;
      run_txn(we, addr, $urandom, ack_at, d, poke, lat, err, en, st, nr);
      model(addr, ack_at, e_lat, e_err, e_en, acked);
      if (acked && !we) rd_model = d;
      n_cmp++; if (lat !== e_lat || err !== e_err) begin n_fail++;
        $display("FAIL rnd%0d_resp: got lat=%0d err=%b want lat=%0d err=%b", t, lat, err,
                 e_lat, e_err); end
      n_cmp++; if (en !== e_en || st !== 1'b1 || nr !== 1) begin n_fail++;
        $display("FAIL rnd%0d_mem: got en=%0d stable=%b n=%0d want en=%0d stable=1 n=1", t, en,
                 st, nr, e_en); end
      n_cmp++; if (rdata !== rd_model) begin n_fail++;
        $display("FAIL rnd%0d_rdata: got %h want %h", t, rdata, rd_model); end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_wait_write();
    test_timeout();
    test_ack_last();
    test_misaligned_busy();
    test_reset_mid_req();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
